// File: rtl/dcache_port_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dcache_port_arbiter_if : requester-side and dcache-side buses of the arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
interface dcache_port_arbiter_if #(
  parameter int NrPorts   = 3,
  parameter int AddrWidth = 64,
  parameter int DataWidth = 64
);
  logic [NrPorts-1:0]               req;
  logic [NrPorts*AddrWidth-1:0]     addr;
  logic [NrPorts-1:0]               we;
  logic [NrPorts*(DataWidth/8)-1:0] be;
  logic [NrPorts*DataWidth-1:0]     wdata;
  logic [NrPorts-1:0]               gnt;
  logic [NrPorts-1:0]               rvalid;
  logic [DataWidth-1:0]             rdata;

  logic                             dc_req;
  logic [AddrWidth-1:0]             dc_addr;
  logic                             dc_we;
  logic [DataWidth/8-1:0]           dc_be;
  logic [DataWidth-1:0]             dc_wdata;
  logic                             dc_gnt;
  logic                             dc_rvalid;
  logic [DataWidth-1:0]             dc_rdata;

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata,
    output dc_req, dc_addr, dc_we, dc_be, dc_wdata,
    input  dc_gnt, dc_rvalid, dc_rdata
  );

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata,
    input  dc_req, dc_addr, dc_we, dc_be, dc_wdata,
    output dc_gnt, dc_rvalid, dc_rdata
  );
endinterface
`default_nettype wire

// File: rtl/dcache_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dcache_port_arbiter : shares one WB dcache request port among NrPorts units,
// in-order response routing. Option: DCACHE_ARB_STARVE_GUARD_EN.
// Rev 1.0
// ----------------------------------------------------------------------------
module dcache_port_arbiter #(
  parameter int  NrPorts        = 3,
  parameter int  AddrWidth      = 64,
  parameter int  DataWidth      = 64,
  parameter int  MaxOutstanding = 7,
  localparam int PtrWidth       = $clog2(NrPorts)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  dcache_port_arbiter_if.slave  bus,
  output logic                  idle_o,
  output logic                  resp_err_o
);
  localparam int BeWidth  = DataWidth / 8;
  localparam int CntWidth = $clog2(MaxOutstanding + 1);
  localparam int FifoPtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [CntWidth-1:0] MaxCnt   = CntWidth'(MaxOutstanding);
  localparam logic [FifoPtrW-1:0] LastSlot = FifoPtrW'(MaxOutstanding - 1);
  localparam logic [PtrWidth-1:0] LastPort = PtrWidth'(NrPorts - 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [PtrWidth-1:0] lock_idx_q, lock_idx_d;
  logic [PtrWidth-1:0] rr_ptr_q, rr_ptr_d;
  logic [PtrWidth-1:0] fifo_q [MaxOutstanding];
  logic [FifoPtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0] count_q;
  logic                resp_err_q;

  logic [PtrWidth-1:0] rr_winner, winner, cur_idx;
  logic                rr_found, win_valid, can_lock, issue, push, pop, fifo_empty;
  int                  cand;

  always_comb begin
    rr_winner = '0;
    rr_found  = 1'b0;
    cand      = 0;
    for (int k = 0; k < NrPorts - 1; k++) begin
      cand = ((int'(rr_ptr_q) - 1 + k) % (NrPorts - 1)) + 1;
      if (!rr_found && bus.req[PtrWidth'(cand)]) begin
        rr_found  = 1'b1;
        rr_winner = PtrWidth'(cand);
      end
    end
  end

`ifdef DCACHE_ARB_STARVE_GUARD_EN
  logic [3:0]          wait_q [NrPorts];
  logic                starve_hit;
  logic [PtrWidth-1:0] starve_idx;

  always_comb begin
    starve_hit = 1'b0;
    starve_idx = '0;
    for (int p = 0; p < NrPorts; p++) begin
      if (!starve_hit && wait_q[p] == 4'hF && bus.req[p]) begin
        starve_hit = 1'b1;
        starve_idx = PtrWidth'(p);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NrPorts; p++) begin
      if (rst_i || bus.gnt[p]) begin
        wait_q[p] <= 4'd0;
      end else if (bus.req[p] && wait_q[p] != 4'hF) begin
        wait_q[p] <= wait_q[p] + 4'd1;
      end
    end
  end
`endif

  always_comb begin
    winner    = rr_winner;
    win_valid = rr_found;
    if (bus.req[0]) begin
      winner    = '0;
      win_valid = 1'b1;
    end
`ifdef DCACHE_ARB_STARVE_GUARD_EN
    if (starve_hit) begin
      winner    = starve_idx;
      win_valid = 1'b1;
    end
`endif
  end

  // Full check uses the registered count only, so dc_rvalid_i never reaches dc_req_o.
  assign fifo_empty = (count_q == '0);
  assign can_lock   = !rst_i && !flush_i && (state_q == ST_IDLE) && (count_q != MaxCnt) && win_valid;
  assign issue      = ((state_q == ST_LOCKED) && !rst_i) || can_lock;
  assign cur_idx    = (state_q == ST_LOCKED) ? lock_idx_q : winner;
  assign push       = issue && bus.dc_gnt;
  assign pop        = !rst_i && bus.dc_rvalid && !fifo_empty;

  assign bus.dc_req   = issue;
  assign bus.dc_addr  = bus.addr[int'(cur_idx) * AddrWidth +: AddrWidth];
  assign bus.dc_we    = bus.we[cur_idx];
  assign bus.dc_be    = bus.be[int'(cur_idx) * BeWidth +: BeWidth];
  assign bus.dc_wdata = bus.wdata[int'(cur_idx) * DataWidth +: DataWidth];
  assign bus.rdata    = bus.dc_rdata;

  always_comb begin
    bus.gnt    = '0;
    bus.rvalid = '0;
    if (push) bus.gnt[cur_idx] = 1'b1;
    if (pop)  bus.rvalid[fifo_q[rd_ptr_q]] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    if (push) begin
      state_d = ST_IDLE;
      if (cur_idx != '0) begin
        rr_ptr_d = (cur_idx == LastPort) ? PtrWidth'(1) : cur_idx + PtrWidth'(1);
      end
    end else if (can_lock) begin
      state_d    = ST_LOCKED;
      lock_idx_d = winner;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      lock_idx_q <= '0;
      rr_ptr_q   <= PtrWidth'(1);
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      resp_err_q <= bus.dc_rvalid && fifo_empty;
      if (push) begin
        fifo_q[wr_ptr_q] <= cur_idx;
        wr_ptr_q         <= (wr_ptr_q == LastSlot) ? '0 : wr_ptr_q + FifoPtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == LastSlot) ? '0 : rd_ptr_q + FifoPtrW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CntWidth'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntWidth'(1);
      end
    end
  end

  assign idle_o     = (state_q == ST_IDLE) && fifo_empty;
  assign resp_err_o = resp_err_q;
endmodule
`default_nettype wire

// File: tb/tb_dcache_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dcache_port_arbiter : directed scenarios plus random traffic against a
// queue-based reference model of the arbiter. Rev 1.0
// ----------------------------------------------------------------------------
module tb_dcache_port_arbiter;
  localparam int NP = 3;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int BW = DW / 8;
  localparam int MO = 7;

  logic clk = 1'b0;
  logic rst, flush, idle, resp_err;

  dcache_port_arbiter_if #(.NrPorts(NP), .AddrWidth(AW), .DataWidth(DW)) bus ();

  dcache_port_arbiter #(
    .NrPorts(NP), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(bus),
    .idle_o(idle), .resp_err_o(resp_err)
  );

  always #5 clk = ~clk;

  // requester and downstream stimulus
  logic [NP-1:0] p_req;
  logic [AW-1:0] p_addr  [NP];
  logic          p_we    [NP];
  logic [BW-1:0] p_be    [NP];
  logic [DW-1:0] p_wdata [NP];
  logic          dgnt, drv;
  logic [DW-1:0] drdata;

  // reference model
  bit      m_locked;
  int      m_lock;
  int      m_rr;
  int      m_q[$];
  bit      m_err;
  int      m_wait[NP];
  bit      e_issue, e_pop;
  int      e_idx;
  logic [NP-1:0] e_gnt, e_rv;

  logic          obs_dcreq, obs_idle, obs_err;
  logic [NP-1:0] obs_gnt, obs_rvalid;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_rdata;

  int n_vec, n_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic new_req(input int p);
    p_req[p]   = 1'b1;
    p_addr[p]  = {$urandom, $urandom};
    p_we[p]    = 1'($urandom);
    p_be[p]    = BW'($urandom);
    p_wdata[p] = {$urandom, $urandom};
  endtask

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      bus.addr[p*AW +: AW]  = p_addr[p];
      bus.we[p]             = p_we[p];
      bus.be[p*BW +: BW]    = p_be[p];
      bus.wdata[p*DW +: DW] = p_wdata[p];
    end
    bus.req       = p_req;
    bus.dc_gnt    = dgnt;
    bus.dc_rvalid = drv;
    bus.dc_rdata  = drdata;
  endtask

  // Port 0 first, then ports in round-robin order starting at the pointer.
  function automatic int pick_port();
    int order[$];
`ifdef DCACHE_ARB_STARVE_GUARD_EN
    for (int p = 0; p < NP; p++) if (m_wait[p] >= 15 && p_req[p]) return p;
`endif
    if (p_req[0]) return 0;
    for (int p = m_rr; p < NP; p++) order.push_back(p);
    for (int p = 1; p < m_rr; p++) order.push_back(p);
    foreach (order[i]) if (p_req[order[i]]) return order[i];
    return -1;
  endfunction

  task automatic check_cycle();
    int w;
    e_issue = 1'b0;
    e_idx   = 0;
    if (!rst) begin
      if (m_locked) begin
        e_issue = 1'b1;
        e_idx   = m_lock;
      end else if (!flush && m_q.size() < MO) begin
        w = pick_port();
        if (w >= 0) begin
          e_issue = 1'b1;
          e_idx   = w;
        end
      end
    end
    e_gnt = '0;
    if (e_issue && dgnt) e_gnt[e_idx] = 1'b1;
    e_pop = !rst && drv && (m_q.size() > 0);
    e_rv  = '0;
    if (e_pop) e_rv[m_q[0]] = 1'b1;

    obs_dcreq  = bus.dc_req;
    obs_gnt    = bus.gnt;
    obs_rvalid = bus.rvalid;
    obs_rdata  = bus.rdata;
    obs_addr   = bus.dc_addr;
    obs_idle   = idle;
    obs_err    = resp_err;

    chk("dc_req",   64'(obs_dcreq),  64'(e_issue));
    chk("gnt",      64'(obs_gnt),    64'(e_gnt));
    chk("rvalid",   64'(obs_rvalid), 64'(e_rv));
    chk("idle",     64'(obs_idle),   64'(!m_locked && m_q.size() == 0));
    chk("resp_err", 64'(obs_err),    64'(m_err));
    if (e_issue) begin
      chk("dc_addr",  obs_addr,            p_addr[e_idx]);
      chk("dc_we",    64'(bus.dc_we),      64'(p_we[e_idx]));
      chk("dc_be",    64'(bus.dc_be),      64'(p_be[e_idx]));
      chk("dc_wdata", bus.dc_wdata,        p_wdata[e_idx]);
    end
    if (e_pop) chk("rdata", obs_rdata, drdata);
  endtask

  task automatic update();
    if (rst) begin
      m_locked = 1'b0;
      m_q.delete();
      m_rr  = 1;
      m_err = 1'b0;
      for (int p = 0; p < NP; p++) m_wait[p] = 0;
    end else begin
      m_err = drv && (m_q.size() == 0);
      if (e_pop) void'(m_q.pop_front());
      for (int p = 0; p < NP; p++) begin
        if (e_gnt[p]) m_wait[p] = 0;
        else if (p_req[p] && m_wait[p] < 15) m_wait[p]++;
      end
      if (e_gnt != '0) begin
        m_q.push_back(e_idx);
        m_locked     = 1'b0;
        p_req[e_idx] = 1'b0;
        if (e_idx != 0) m_rr = (e_idx == NP - 1) ? 1 : e_idx + 1;
      end else if (e_issue) begin
        m_locked = 1'b1;
        m_lock   = e_idx;
      end
    end
  endtask

  task automatic tick();
    drive();
    #2;
    check_cycle();
    @(posedge clk);
    #1;
    update();
  endtask

  // Finish pending requests and outstanding responses, bounded.
  task automatic drain();
    dgnt  = 1'b1;
    flush = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (p_req == '0 && !m_locked && m_q.size() == 0) break;
      drv    = (m_q.size() > 0);
      drdata = {$urandom, $urandom};
      tick();
    end
    drv = 1'b0;
    chk("drain_done", 64'(p_req == '0 && !m_locked && m_q.size() == 0), 64'(1));
  endtask

  logic [AW-1:0] a1;

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; flush = 1'b0; p_req = '0;
    dgnt = 1'b0; drv = 1'b0; drdata = '0;
    m_locked = 1'b0; m_lock = 0; m_rr = 1; m_err = 1'b0;
    for (int p = 0; p < NP; p++) begin
      p_addr[p] = '0; p_we[p] = 1'b0; p_be[p] = '0; p_wdata[p] = '0; m_wait[p] = 0;
    end
    drive();
    @(posedge clk);
    #1;

    // reset state
    tick();
    tick();
    chk("reset_idle",   64'(obs_idle),  64'(1));
    chk("reset_dc_req", 64'(obs_dcreq), 64'(0));
    rst = 1'b0;

    // single port-1 transaction, response two cycles later
    new_req(1); dgnt = 1'b1;
    tick();
    chk("t1_gnt", 64'(obs_gnt), 64'(3'b010));
    dgnt = 1'b0;
    tick();
    drv = 1'b1; drdata = 64'hDEAD;
    tick();
    chk("t1_rvalid", 64'(obs_rvalid), 64'(3'b010));
    chk("t1_rdata",  obs_rdata,       64'hDEAD);
    drv = 1'b0;
    tick();
    chk("t1_idle", 64'(obs_idle), 64'(1));

    // fixed priority for port 0, then round robin between 1 and 2
    dgnt = 1'b1;
    for (int i = 0; i < 6; i++) begin
      for (int p = 0; p < NP; p++) if (!p_req[p]) new_req(p);
      drv = (m_q.size() > 0); drdata = {$urandom, $urandom};
      tick();
      chk("t2_fixed", 64'(obs_gnt), 64'(3'b001));
    end
    for (int i = 0; i < 6; i++) begin
      for (int p = 1; p < NP; p++) if (!p_req[p]) new_req(p);
      drv = (m_q.size() > 0); drdata = {$urandom, $urandom};
      tick();
      chk("t2_rr", 64'(obs_gnt), (i % 2 == 0) ? 64'(3'b100) : 64'(3'b010));
    end
    drain();

    // lock held while dc_gnt_i stays low
    new_req(1); a1 = p_addr[1]; dgnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) new_req(0);
      tick();
      chk("t3_addr", obs_addr, a1);
    end
    dgnt = 1'b1;
    tick();
    chk("t3_first", 64'(obs_gnt), 64'(3'b010));
    tick();
    chk("t3_second", 64'(obs_gnt), 64'(3'b001));
    drain();

    // outstanding limit
    dgnt = 1'b1; drv = 1'b0;
    for (int i = 0; i < MO; i++) begin
      if (!p_req[2]) new_req(2);
      tick();
      chk("t4_fill", 64'(obs_gnt), 64'(3'b100));
    end
    new_req(2);
    tick();
    chk("t4_block", 64'(obs_dcreq), 64'(0));
    drv = 1'b1;
    tick();
    chk("t4_pop_same", 64'(obs_dcreq), 64'(0));
    drv = 1'b0;
    tick();
    chk("t4_resume", 64'(obs_dcreq), 64'(1));
    drain();

    // in-order response routing and unexpected response
    dgnt = 1'b1; drv = 1'b0;
    new_req(2); tick();
    new_req(1); tick();
    new_req(0); tick();
    drv = 1'b1;
    tick(); chk("t5_r0", 64'(obs_rvalid), 64'(3'b100));
    tick(); chk("t5_r1", 64'(obs_rvalid), 64'(3'b010));
    tick(); chk("t5_r2", 64'(obs_rvalid), 64'(3'b001));
    tick(); chk("t5_extra", 64'(obs_rvalid), 64'(0));
    drv = 1'b0;
    tick(); chk("t5_err", 64'(obs_err), 64'(1));
    tick(); chk("t5_err_end", 64'(obs_err), 64'(0));

    // reset in the middle of a locked burst
    new_req(1); new_req(2); dgnt = 1'b0;
    tick();
    rst = 1'b1; drv = 1'b1;
    tick();
    tick();
    chk("t6_dc_req", 64'(obs_dcreq),  64'(0));
    chk("t6_gnt",    64'(obs_gnt),    64'(0));
    chk("t6_rvalid", 64'(obs_rvalid), 64'(0));
    chk("t6_err",    64'(obs_err),    64'(0));
    chk("t6_idle",   64'(obs_idle),   64'(1));
    rst = 1'b0; p_req = '0;
    tick();
    drv = 1'b0;
    tick();
    chk("t6_late_rsp", 64'(obs_err), 64'(1));
    drain();

    // random traffic
    for (int c = 0; c < 2500; c++) begin
      rst   = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 7) == 0);
      for (int p = 0; p < NP; p++) if (!p_req[p] && $urandom_range(0, 2) == 0) new_req(p);
      dgnt   = ($urandom_range(0, 9) < 6);
      drv    = (m_q.size() > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 49) == 0);
      drdata = {$urandom, $urandom};
      tick();
    end
    rst = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
